// File: rtl/dot_product_accumulator.sv
// Dot-product accumulator: sums VECTOR_LEN unsigned products and queues each sum in a 2-entry FIFO.
// Optional feature macro DOT_ACC_LAST_EN adds i_last to close a vector early.
module dot_product_accumulator #(
    parameter int DATAWIDTH   = 4,
    parameter int VECTOR_LEN  = 8,
    parameter int ACC_WIDTH   = 2*DATAWIDTH + $clog2(VECTOR_LEN),
    parameter int INSTANCE_ID = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_valid,
    input  logic [2*DATAWIDTH-1:0] i_product,
`ifdef DOT_ACC_LAST_EN
    input  logic                   i_last,
`endif
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic [ACC_WIDTH-1:0]   o_sum,
    output logic                   o_busy,
    output logic                   o_drop_err
);

    localparam int CNT_W = $clog2(VECTOR_LEN);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(VECTOR_LEN - 1);

    typedef enum logic {IDLE, ACCUM} state_t;

    state_t               r_state;
    state_t               w_nextState;
    logic [CNT_W-1:0]     r_count;
    logic [CNT_W-1:0]     w_nextCount;
    logic [ACC_WIDTH-1:0] r_acc;
    logic [ACC_WIDTH-1:0] w_nextAcc;
    logic [ACC_WIDTH-1:0] w_sum;
    logic                 w_close;
    logic                 w_lastTerm;

    logic [ACC_WIDTH-1:0] r_fifoMem [0:1];
    logic                 r_wrPtr;
    logic                 r_rdPtr;
    logic [1:0]           r_fifoCnt;
    logic                 r_dropErr;
    logic                 w_full;
    logic                 w_pop;
    logic                 w_push;
    logic                 w_drop;
    logic                 w_unusedId;

    assign w_unusedId = ^INSTANCE_ID;

`ifdef DOT_ACC_LAST_EN
    assign w_lastTerm = i_last;
`else
    assign w_lastTerm = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_count <= '0;
            r_acc   <= '0;
        end else begin
            r_state <= w_nextState;
            r_count <= w_nextCount;
            r_acc   <= w_nextAcc;
        end
    end

    // A fresh vector starts from zero rather than the held accumulator value.
    always_comb begin
        w_nextState = r_state;
        w_nextCount = r_count;
        w_nextAcc   = r_acc;
        w_close     = 1'b0;
        w_sum       = ((r_state == IDLE) ? '0 : r_acc) + ACC_WIDTH'(i_product);
        if (i_valid) begin
            if ((r_count == LAST_CNT) || w_lastTerm) begin
                w_close     = 1'b1;
                w_nextState = IDLE;
                w_nextCount = '0;
                w_nextAcc   = '0;
            end else begin
                w_nextState = ACCUM;
                w_nextCount = r_count + CNT_W'(1);
                w_nextAcc   = w_sum;
            end
        end
    end

    assign w_full = (r_fifoCnt == 2'd2);
    assign w_pop  = o_valid && i_ready;
    assign w_push = w_close && (!w_full || w_pop);
    assign w_drop = w_close && w_full && !w_pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fifoMem[0] <= '0;
            r_fifoMem[1] <= '0;
            r_wrPtr      <= 1'b0;
            r_rdPtr      <= 1'b0;
            r_fifoCnt    <= 2'd0;
            r_dropErr    <= 1'b0;
        end else begin
            if (w_push) begin
                r_fifoMem[r_wrPtr] <= w_sum;
                r_wrPtr            <= ~r_wrPtr;
            end
            if (w_pop) begin
                r_rdPtr <= ~r_rdPtr;
            end
            if (w_push && !w_pop) begin
                r_fifoCnt <= r_fifoCnt + 2'd1;
            end else if (w_pop && !w_push) begin
                r_fifoCnt <= r_fifoCnt - 2'd1;
            end
            if (w_drop) begin
                r_dropErr <= 1'b1;
            end
        end
    end

    assign o_valid    = (r_fifoCnt != 2'd0);
    assign o_sum      = o_valid ? r_fifoMem[r_rdPtr] : '0;
    assign o_busy     = (r_count != '0);
    assign o_drop_err = r_dropErr;

endmodule

// File: tb/tb_dot_product_accumulator.sv
// Scoreboard bench for dot_product_accumulator: directed scenarios plus randomized traffic.
// Honours DOT_ACC_LAST_EN when the design is built with it.
module tb_dot_product_accumulator;

    localparam int DW = 4;
    localparam int VL = 4;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          validIn = 1'b0;
    logic [2*DW-1:0] productIn = '0;
    logic          lastIn = 1'b0;
    logic          readyIn = 1'b1;
    logic          o_valid;
    logic [AW-1:0] o_sum;
    logic          o_busy;
    logic          o_drop_err;

    int vectorCount = 0;
    int missCount   = 0;

    int  terms [$];
    int  expQ  [$];
    int  mOcc = 0;
    bit  expDrop = 1'b0;
    bit  mPop;
    bit  mClose;
    int  mSum;
    bit  stallPrev = 1'b0;
    logic [AW-1:0] sumPrev = '0;

    dot_product_accumulator #(
        .DATAWIDTH(DW),
        .VECTOR_LEN(VL),
        .ACC_WIDTH(AW),
        .INSTANCE_ID(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .i_valid(validIn),
        .i_product(productIn),
`ifdef DOT_ACC_LAST_EN
        .i_last(lastIn),
`endif
        .o_valid(o_valid),
        .i_ready(readyIn),
        .o_sum(o_sum),
        .o_busy(o_busy),
        .o_drop_err(o_drop_err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectorCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input bit v, input int p, input bit l, input bit r);
        @(posedge clk);
        #1;
        validIn   = v;
        productIn = (2*DW)'(p);
        lastIn    = l;
        readyIn   = r;
    endtask

    task automatic idle(input int n, input bit r);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 0, 1'b0, r);
    endtask

    task automatic sendVector(input int a, input int b, input int c, input int d, input bit r);
        applyStimulus(1'b1, a, 1'b0, r);
        applyStimulus(1'b1, b, 1'b0, r);
        applyStimulus(1'b1, c, 1'b0, r);
        applyStimulus(1'b1, d, 1'b0, r);
    endtask

    task automatic doReset();
        @(posedge clk);
        #1;
        validIn = 1'b0;
        lastIn  = 1'b0;
        rst     = 1'b1;
        #1;
        checkOutput("rstValid", 32'(o_valid), 0);
        checkOutput("rstSum", 32'(o_sum), 0);
        checkOutput("rstBusy", 32'(o_busy), 0);
        checkOutput("rstDropErr", 32'(o_drop_err), 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Reference model: collects terms per vector, sums them, and tracks FIFO occupancy with pop-before-push.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            terms.delete();
            expQ.delete();
            mOcc    = 0;
            expDrop = 1'b0;
        end else begin
            mPop   = (mOcc > 0) && readyIn;
            mClose = 1'b0;
            if (validIn) begin
                terms.push_back(int'(productIn));
                mClose = (terms.size() == VL);
`ifdef DOT_ACC_LAST_EN
                mClose = mClose || lastIn;
`endif
            end
            if (mPop) mOcc--;
            if (mClose) begin
                mSum = 0;
                foreach (terms[k]) mSum += terms[k];
                terms.delete();
                if (mOcc < 2) begin
                    mOcc++;
                    expQ.push_back(mSum);
                end else begin
                    expDrop = 1'b1;
                end
            end
        end
    end

    // Monitor: pops the scoreboard on every handshake and checks status outputs each cycle.
    always @(negedge clk) begin
        if (rst) begin
            stallPrev = 1'b0;
        end else begin
            checkOutput("validVsModel", 32'(o_valid), 32'(mOcc != 0));
            checkOutput("busy", 32'(o_busy), 32'(terms.size() != 0));
            checkOutput("dropErr", 32'(o_drop_err), 32'(expDrop));
            if (!o_valid) checkOutput("sumWhenEmpty", 32'(o_sum), 0);
            if (stallPrev) checkOutput("sumStable", 32'(o_sum), 32'(sumPrev));
            if (o_valid && readyIn) begin
                if (expQ.size() == 0) checkOutput("sumExpected", 32'(expQ.size() != 0), 1);
                else checkOutput("sum", 32'(o_sum), 32'(expQ.pop_front()));
            end
            stallPrev = o_valid && !readyIn;
            sumPrev   = o_sum;
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        checkOutput("initValid", 32'(o_valid), 0);
        checkOutput("initSum", 32'(o_sum), 0);
        checkOutput("initBusy", 32'(o_busy), 0);
        checkOutput("initDropErr", 32'(o_drop_err), 0);
        rst = 1'b0;

        $display("[TB] basic vector and restart from zero");
        sendVector(1, 2, 3, 4, 1'b1);
        idle(3, 1'b1);
        sendVector(2, 3, 1, 0, 1'b1);
        idle(3, 1'b1);

        $display("[TB] maximum products with gaps");
        for (int i = 0; i < VL; i++) begin
            applyStimulus(1'b1, 225, 1'b0, 1'b1);
            idle(2, 1'b1);
        end
        idle(3, 1'b1);

        $display("[TB] backpressure fills FIFO and drops third sum");
        sendVector(1, 1, 1, 1, 1'b0);
        sendVector(2, 2, 2, 2, 1'b0);
        sendVector(3, 3, 3, 3, 1'b0);
        idle(2, 1'b0);
        checkOutput("dropSticky", 32'(o_drop_err), 1);
        idle(6, 1'b1);
        doReset();

        $display("[TB] simultaneous push and pop while full");
        sendVector(1, 1, 1, 1, 1'b0);
        sendVector(2, 2, 2, 2, 1'b0);
        applyStimulus(1'b1, 3, 1'b0, 1'b0);
        applyStimulus(1'b1, 3, 1'b0, 1'b0);
        applyStimulus(1'b1, 3, 1'b0, 1'b0);
        applyStimulus(1'b1, 3, 1'b0, 1'b1);
        idle(6, 1'b1);
        checkOutput("noDropOnPushPop", 32'(o_drop_err), 0);

        $display("[TB] reset mid-vector");
        applyStimulus(1'b1, 7, 1'b0, 1'b1);
        applyStimulus(1'b1, 7, 1'b0, 1'b1);
        doReset();
        sendVector(1, 2, 3, 4, 1'b1);
        idle(3, 1'b1);

`ifdef DOT_ACC_LAST_EN
        $display("[TB] early termination with last");
        applyStimulus(1'b0, 9, 1'b1, 1'b1);
        applyStimulus(1'b1, 5, 1'b0, 1'b1);
        applyStimulus(1'b1, 6, 1'b1, 1'b1);
        idle(3, 1'b1);
        sendVector(1, 1, 1, 1, 1'b1);
        idle(3, 1'b1);
`endif

        $display("[TB] randomized traffic");
        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 9) < 7,
                          int'($urandom_range(0, 15) * $urandom_range(0, 15)),
                          $urandom_range(0, 6) == 0,
                          $urandom_range(0, 1) == 1);
        end

        for (int i = 0; i < 20; i++) begin
            if (expQ.size() == 0 && !o_valid) break;
            idle(1, 1'b1);
        end
        idle(2, 1'b1);
        checkOutput("drainEmpty", 32'(expQ.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
